mesh_sequencer: RTL and testbench
=================================

# mesh_sequencer

Drives an N×N FP32 `Mesh` through a complete C = A·B matrix multiply with inner dimension K, then drains every PE accumulator as a result stream. It replaces the hand-sequenced stimulus currently in mesh benches: clear, K injection steps, diagonal-completion wait, per-PE accumulator readout. It sits between an operand source (one A column plus one B row per beat) and a result sink, and owns the mesh's reset and select lines.

## Interface
- `N`, 3, mesh dimension (rows = cols).
- `DATA_WIDTH`, 32, operand/result width (FP32 bit patterns, never interpreted).
- `K_MAX`, 16, largest supported inner dimension.
- `GAP_CYCLES`, 5, idle cycles between injection steps.
- `TIMEOUT`, 1024, cycle limit for any single mesh wait.
- `clk_i`  in  1  clock; the single clock domain.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  begin an operation; sampled only in IDLE.
- `k_len_i`  in  $clog2(K_MAX+1)  inner dimension; latched with `start_i`.
- `busy_o`  out  1  high from the cycle after start accept until the `done_o` cycle, inclusive.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  sticky timeout flag; cleared by the next accepted start.
- `a_col_i`  in  N*DATA_WIDTH  A[i][k] in slice i.
- `b_row_i`  in  N*DATA_WIDTH  B[k][j] in slice j.
- `op_valid_i` / `op_ready_o`  in / out  1  operand beat handshake.
- `mesh_rstn_o`  out  1  registered active-low mesh reset.
- `mesh_north_o`, `mesh_west_o`  out  N*DATA_WIDTH  mesh inputs.
- `mesh_inputs_valid_o`  out  1  mesh injection strobe.
- `mesh_select_acc_o`  out  N*N  select bit for PE (r,c) at bit r*N+c.
- `mesh_passthrough_valid_i`, `mesh_accumulator_valid_i`  in  N*N  mesh status, same bit order.
- `mesh_acc_data_i`  in  N*N*DATA_WIDTH  value of PE (r,c) at slice r*N+c.
- `res_data_o`  out  DATA_WIDTH  C[r][c].
- `res_row_o`, `res_col_o`  out  $clog2(N)  coordinates of the result.
- `res_valid_o` / `res_ready_i`  out / in  1  result handshake.
- `res_last_o`  out  1  high with the final (N-1,N-1) beat.

## Operation
- FSM states: IDLE → CLEAR → SETTLE → FETCH → PRE → ISSUE → WAIT_DIAG → GAP → (FETCH | DRAIN_SEL) → DRAIN_OUT → … → DONE → IDLE.
- IDLE: on `start_i`, latch min(`k_len_i`, K_MAX), clear `err_o` and the step counter.
- CLEAR: `mesh_rstn_o` low for 2 cycles. SETTLE: high for 2 cycles. If k_len = 0, go straight to DRAIN_SEL (all nine results are 0x00000000 for N=3).
- FETCH: `op_ready_o`=1. When the beat is accepted, register `a_col_i` → `mesh_west_o` and `b_row_i` → `mesh_north_o`. Both hold until the next accept.
- PRE: one cycle with the data stable and the strobe low. ISSUE: `mesh_inputs_valid_o`=1 for exactly one cycle. Sticky diagonal flags clear in ISSUE.
- WAIT_DIAG: OR `mesh_passthrough_valid_i[i*N+i]` into the sticky flags. Leave WAIT_DIAG once all N flags are set. Pulses that arrive in any order or in the same cycle all count.
- GAP: GAP_CYCLES cycles. Then step+1: if it is below k_len, go to FETCH, otherwise to DRAIN_SEL.
- DRAIN_SEL (raster index 0..N*N-1): assert the select bit for the current index. On the first cycle `mesh_accumulator_valid_i` for that index is sampled high, capture its `mesh_acc_data_i` slice.
- DRAIN_OUT: select deasserted, `res_valid_o`=1 holding the captured value. Advance on `res_valid_o & res_ready_i`. At index N*N-1, go to DONE.
- Timeout: a counter resets on each state entry. If WAIT_DIAG or DRAIN_SEL reaches TIMEOUT: set `err_o`, clear all selects and strobes, pulse `done_o`, return to IDLE. No further results are emitted.

## Timing
- Reset values: `mesh_rstn_o`=0 during reset, then 1 from the first clock after release; all other outputs 0; FSM in IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. The partial result stream is discarded.
- `start_i` while busy is ignored.
- Operand accept at cycle T: PRE at T+1, strobe at T+2.
- Result stream: ≤1 beat per 2 cycles. `res_*` stay stable while `res_ready_i`=0.
- `done_o` is high one cycle after the last result handshake. `busy_o` drops the cycle after `done_o`.
- At most one select bit is high at any time.

## Test plan
- Bench setup: N=3, real `Mesh`.
- Identity test: A=1..9 (0x3F800000…0x41100000), B=I, K=3 → results equal A in raster order; `res_last_o` only on beat 9; `err_o`=0.
- Dense test: A={3,2,1;6,5,4;9,8,7}, B={2,4,6;1,3,5;7,8,9} → 0x41700000, 0x41D00000, 0x42140000, 0x42340000, 0x428E0000, 0x42C20000, 0x42960000, 0x42E80000, 0x431D0000.
- Backpressure: dense test with `res_ready_i` toggling randomly and `op_valid_i` gapped → identical stream; outputs stable while stalled; strobe count = 3.
- k_len_i=0 → nine beats of 0x00000000 after CLEAR/SETTLE. k_len_i=K_MAX+3 → exactly K_MAX operand accepts.
- Timeout: diagonal PE (1,1) `passthrough_valid` forced to 0 → `err_o`=1 and `done_o` after TIMEOUT cycles, no results. Next start clears `err_o`.
- Reset during DRAIN_OUT beat 4 → all outputs at reset values next cycle. A new start completes the identity test correctly. A `start_i` pulse mid-run is ignored.

Source files
------------

// File: rtl/mesh_sequencer_if.sv
// Operand, result and mesh-control bundle between mesh_sequencer (master) and its
// neighbours (slave): operand source, result sink and the N x N mesh itself.
interface mesh_sequencer_if #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 32
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic [N*DATA_WIDTH-1:0]   a_col_i;
  logic [N*DATA_WIDTH-1:0]   b_row_i;
  logic                      op_valid_i;
  logic                      op_ready_o;

  logic                      mesh_rstn_o;
  logic [N*DATA_WIDTH-1:0]   mesh_north_o;
  logic [N*DATA_WIDTH-1:0]   mesh_west_o;
  logic                      mesh_inputs_valid_o;
  logic [N*N-1:0]            mesh_select_acc_o;
  logic [N*N-1:0]            mesh_passthrough_valid_i;
  logic [N*N-1:0]            mesh_accumulator_valid_i;
  logic [N*N*DATA_WIDTH-1:0] mesh_acc_data_i;

  logic [DATA_WIDTH-1:0]     res_data_o;
  logic [RW-1:0]             res_row_o;
  logic [RW-1:0]             res_col_o;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic                      res_last_o;

  modport master (
    input  a_col_i, b_row_i, op_valid_i,
    input  mesh_passthrough_valid_i, mesh_accumulator_valid_i, mesh_acc_data_i,
    input  res_ready_i,
    output op_ready_o,
    output mesh_rstn_o, mesh_north_o, mesh_west_o, mesh_inputs_valid_o, mesh_select_acc_o,
    output res_data_o, res_row_o, res_col_o, res_valid_o, res_last_o
  );

  modport slave (
    output a_col_i, b_row_i, op_valid_i,
    output mesh_passthrough_valid_i, mesh_accumulator_valid_i, mesh_acc_data_i,
    output res_ready_i,
    input  op_ready_o,
    input  mesh_rstn_o, mesh_north_o, mesh_west_o, mesh_inputs_valid_o, mesh_select_acc_o,
    input  res_data_o, res_row_o, res_col_o, res_valid_o, res_last_o
  );
endinterface

// File: rtl/mesh_sequencer.sv
// Sequences a full C = A*B on an N x N mesh: clear, K injection steps, then raster drain of all PEs.
// Latency: operand accept to mesh strobe is 2 cycles; each result takes at least 2 cycles.
// Backpressure: operands wait on op_ready; results hold stable while res_ready is low.
module mesh_sequencer #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int K_MAX      = 16,
  parameter int GAP_CYCLES = 5,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start_i,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  mesh_sequencer_if.master             bus
);
  localparam int NN = N * N;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NN-1:0] SEL_ONE = NN'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_FETCH, S_PRE, S_ISSUE,
    S_WAIT_DIAG, S_GAP, S_DRAIN_SEL, S_DRAIN_OUT, S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_len;
  logic [KW-1:0] step;
  logic [KW:0]   step_nxt;
  logic [TW-1:0] cnt;
  logic [N-1:0]  diag_flags;
  logic [N-1:0]  diag_now;
  logic [IW-1:0] idx;
  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic          timed_out;

  // Diagonal pulses may arrive in any order, so fold this cycle's pulses into the sticky set.
  always_comb begin
    diag_now = diag_flags;
    for (int i = 0; i < N; i++)
      diag_now[i] = diag_flags[i] | bus.mesh_passthrough_valid_i[i*N+i];
  end

  assign step_nxt  = {1'b0, step} + {{KW{1'b0}}, 1'b1};
  assign timed_out = (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state                   <= S_IDLE;
      k_len                   <= '0;
      step                    <= '0;
      cnt                     <= '0;
      diag_flags              <= '0;
      idx                     <= '0;
      row                     <= '0;
      col                     <= '0;
      busy_o                  <= 1'b0;
      done_o                  <= 1'b0;
      err_o                   <= 1'b0;
      bus.op_ready_o          <= 1'b0;
      bus.mesh_rstn_o         <= 1'b0;
      bus.mesh_north_o        <= '0;
      bus.mesh_west_o         <= '0;
      bus.mesh_inputs_valid_o <= 1'b0;
      bus.mesh_select_acc_o   <= '0;
      bus.res_data_o          <= '0;
      bus.res_row_o           <= '0;
      bus.res_col_o           <= '0;
      bus.res_valid_o         <= 1'b0;
      bus.res_last_o          <= 1'b0;
    end else begin
      cnt <= cnt + TW'(1);
      case (state)
        S_IDLE: begin
          bus.mesh_rstn_o <= 1'b1;
          if (start_i) begin
            k_len           <= (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
            step            <= '0;
            err_o           <= 1'b0;
            busy_o          <= 1'b1;
            bus.mesh_rstn_o <= 1'b0;
            cnt             <= '0;
            state           <= S_CLEAR;
          end
        end
        S_CLEAR: if (cnt == TW'(1)) begin
          bus.mesh_rstn_o <= 1'b1;
          cnt             <= '0;
          state           <= S_SETTLE;
        end
        S_SETTLE: if (cnt == TW'(1)) begin
          cnt <= '0;
          if (k_len == '0) begin
            idx                   <= '0;
            row                   <= '0;
            col                   <= '0;
            bus.mesh_select_acc_o <= SEL_ONE;
            state                 <= S_DRAIN_SEL;
          end else begin
            bus.op_ready_o <= 1'b1;
            state          <= S_FETCH;
          end
        end
        S_FETCH: if (bus.op_valid_i && bus.op_ready_o) begin
          bus.mesh_west_o  <= bus.a_col_i;
          bus.mesh_north_o <= bus.b_row_i;
          bus.op_ready_o   <= 1'b0;
          state            <= S_PRE;
        end
        S_PRE: begin
          bus.mesh_inputs_valid_o <= 1'b1;
          state                   <= S_ISSUE;
        end
        S_ISSUE: begin
          bus.mesh_inputs_valid_o <= 1'b0;
          diag_flags              <= '0;
          cnt                     <= '0;
          state                   <= S_WAIT_DIAG;
        end
        S_WAIT_DIAG: begin
          diag_flags <= diag_now;
          if (&diag_now) begin
            cnt   <= '0;
            state <= S_GAP;
          end else if (timed_out) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_GAP: if (cnt == TW'(GAP_CYCLES - 1)) begin
          cnt  <= '0;
          step <= step_nxt[KW-1:0];
          if (step_nxt < {1'b0, k_len}) begin
            bus.op_ready_o <= 1'b1;
            state          <= S_FETCH;
          end else begin
            idx                   <= '0;
            row                   <= '0;
            col                   <= '0;
            bus.mesh_select_acc_o <= SEL_ONE;
            state                 <= S_DRAIN_SEL;
          end
        end
        S_DRAIN_SEL: begin
          if (bus.mesh_accumulator_valid_i[idx]) begin
            bus.res_data_o        <= bus.mesh_acc_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
            bus.res_row_o         <= row;
            bus.res_col_o         <= col;
            bus.res_last_o        <= (idx == IW'(NN - 1));
            bus.res_valid_o       <= 1'b1;
            bus.mesh_select_acc_o <= '0;
            state                 <= S_DRAIN_OUT;
          end else if (timed_out) begin
            bus.mesh_select_acc_o <= '0;
            err_o                 <= 1'b1;
            done_o                <= 1'b1;
            state                 <= S_DONE;
          end
        end
        S_DRAIN_OUT: if (bus.res_ready_i) begin
          bus.res_valid_o <= 1'b0;
          bus.res_last_o  <= 1'b0;
          cnt             <= '0;
          if (idx == IW'(NN - 1)) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
            if (col == RW'(N - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
            bus.mesh_select_acc_o <= SEL_ONE << (idx + IW'(1));
            state                 <= S_DRAIN_SEL;
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesh_sequencer.sv
// Bench for mesh_sequencer: behavioural FP32 mesh stand-in, random operand/result handshakes,
// reference C = A*B computed with real arithmetic and checked through a result scoreboard.
`timescale 1ns/1ps
module tb_mesh_sequencer;
  localparam int N          = 3;
  localparam int DW         = 32;
  localparam int K_MAX      = 16;
  localparam int GAP_CYCLES = 5;
  localparam int TIMEOUT    = 1024;
  localparam int KW         = $clog2(K_MAX + 1);
  localparam int NN         = N * N;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } res_t;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [KW-1:0] k_len_i = '0;
  logic          busy_o, done_o, err_o;

  mesh_sequencer_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  mesh_sequencer #(
    .N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, accepts = 0, strobes = 0, popped = 0;
  int   rdy_limit = 1000000, rdy_pct = 100;
  int   last_strobe_cyc = 0, done_cyc = 0;
  bit   pt11_off = 0, op_stop = 0, drv_active = 0;
  res_t exp_q[$];
  logic [DW-1:0] cur_a[N][K_MAX];
  logic [DW-1:0] cur_b[K_MAX][N];
  real  acc[N][N];
  int   diag_cd[N];
  int   sel_wait = 0;
  const int da[N][N] = '{'{3, 2, 1}, '{6, 5, 4}, '{9, 8, 7}};
  const int db[N][N] = '{'{2, 4, 6}, '{1, 3, 5}, '{7, 8, 9}};
  const logic [DW-1:0] dense_c[NN] = '{32'h41700000, 32'h41D00000, 32'h42140000,
                                       32'h42340000, 32'h428E0000, 32'h42C20000,
                                       32'h42960000, 32'h42E80000, 32'h431D0000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({busy_o, done_o, err_o, bus.op_ready_o, bus.mesh_rstn_o, bus.mesh_inputs_valid_o,
                bus.mesh_select_acc_o, bus.res_valid_o, bus.res_last_o, bus.res_data_o});
  endfunction

  always @(posedge clk) cyc++;

  // Behavioural mesh: accumulates on the strobe, answers diagonals and selects after random delays.
  always @(negedge clk) begin
    bus.mesh_passthrough_valid_i = '0;
    bus.mesh_accumulator_valid_i = '0;
    if (!bus.mesh_rstn_o) begin
      for (int r = 0; r < N; r++) begin
        diag_cd[r] = 0;
        for (int c = 0; c < N; c++) acc[r][c] = 0.0;
      end
      sel_wait = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (diag_cd[i] > 0) begin
          diag_cd[i]--;
          if (diag_cd[i] == 0 && !(pt11_off && i == 1)) bus.mesh_passthrough_valid_i[i*N+i] = 1'b1;
        end
      if (bus.mesh_inputs_valid_o) begin
        strobes++;
        last_strobe_cyc = cyc;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            acc[r][c] += f2r(bus.mesh_west_o[r*DW +: DW]) * f2r(bus.mesh_north_o[c*DW +: DW]);
        for (int i = 0; i < N; i++) diag_cd[i] = $urandom_range(1, 6);
      end
      if (bus.mesh_select_acc_o != '0) begin
        if (sel_wait == 0) sel_wait = $urandom_range(1, 3);
        else begin
          sel_wait--;
          if (sel_wait == 0) bus.mesh_accumulator_valid_i = bus.mesh_select_acc_o;
        end
      end else sel_wait = 0;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) bus.mesh_acc_data_i[(r*N+c)*DW +: DW] = r2f(acc[r][c]);
  end

  // Result monitor: drives res_ready, pops the scoreboard on handshake, checks stall stability.
  res_t held;
  bit   stalled = 0;
  always @(negedge clk) begin
    res_t got, e;
    bit   rdy;
    got = {bus.res_data_o, bus.res_row_o, bus.res_col_o, bus.res_last_o};
    if (bus.res_valid_o && stalled) check("res_stable", got, held);
    stalled = 0;
    if (bus.res_valid_o) begin
      rdy = (popped < rdy_limit) && ($urandom_range(0, 99) < rdy_pct);
      bus.res_ready_i = rdy;
      if (rdy) begin
        popped++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: actual=%0h required=none", got);
        end else begin
          e = exp_q.pop_front();
          check("res_beat", got, e);
        end
      end else begin
        stalled = 1;
        held    = got;
      end
    end else bus.res_ready_i = 1'($urandom_range(0, 1));
  end

  bit prev_done = 0;
  always @(negedge clk) begin
    if (prev_done) check("busy_drop", busy_o, 0);
    if (done_o) check("busy_with_done", busy_o, 1);
    if (bus.mesh_select_acc_o != '0) check("select_onehot", $onehot(bus.mesh_select_acc_o), 1);
    prev_done = done_o;
  end

  task automatic drive_ops(input int nb, input int gap_max);
    drv_active = 1;
    for (int k = 0; k < nb && !op_stop; k++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      bus.op_valid_i = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.a_col_i[i*DW +: DW] = cur_a[i][k];
        bus.b_row_i[i*DW +: DW] = cur_b[k][i];
      end
      while (!bus.op_ready_o && !op_stop) @(negedge clk);
      if (op_stop) break;
      accepts++;
      @(negedge clk);
      bus.op_valid_i = 1'b0;
    end
    // Keep offering junk beats: any further accept is an error.
    bus.op_valid_i = 1'b1;
    bus.a_col_i    = {N{32'h40400000}};
    bus.b_row_i    = {N{32'h40400000}};
    while (!op_stop) begin
      if (bus.op_ready_o) accepts++;
      @(negedge clk);
    end
    bus.op_valid_i = 1'b0;
    drv_active = 0;
  endtask

  task automatic load_case(input int kk, input int kind, input bit push);
    res_t e;
    real  s;
    for (int k = 0; k < kk; k++)
      for (int i = 0; i < N; i++) begin
        case (kind)
          0: begin cur_a[i][k] = r2f(real'(3*i + k + 1)); cur_b[k][i] = r2f((i == k) ? 1.0 : 0.0); end
          1: begin cur_a[i][k] = r2f(real'(da[i][k]));   cur_b[k][i] = r2f(real'(db[k][i])); end
          default: begin
            cur_a[i][k] = r2f(real'($urandom_range(0, 16)) - 8.0);
            cur_b[k][i] = r2f(real'($urandom_range(0, 16)) - 8.0);
          end
        endcase
      end
    if (push)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          s = 0.0;
          for (int k = 0; k < kk; k++) s += f2r(cur_a[r][k]) * f2r(cur_b[k][c]);
          e.data = (kind == 1) ? dense_c[r*N+c] : r2f(s);
          e.row  = 2'(r);
          e.col  = 2'(c);
          e.last = (r == N-1) && (c == N-1);
          exp_q.push_back(e);
        end
  endtask

  task automatic start_op(input int kreq);
    accepts = 0;
    strobes = 0;
    popped  = 0;
    op_stop = 0;
    @(negedge clk);
    start_i = 1'b1;
    k_len_i = KW'(kreq);
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("err_cleared", err_o, 0);
  endtask

  task automatic stop_driver();
    int n = 0;
    op_stop = 1;
    while (drv_active && n < 20) begin @(negedge clk); n++; end
    check("driver_idle", drv_active, 0);
  endtask

  task automatic run_op(input int kreq, input int kind, input int gap_max, input bit exp_err,
                        input bit mid_start);
    int kk, n;
    kk = (kreq > K_MAX) ? K_MAX : kreq;
    load_case(kk, kind, !exp_err);
    start_op(kreq);
    fork drive_ops(kk, gap_max); join_none
    if (mid_start) begin
      repeat (15) @(negedge clk);
      start_i = 1'b1;
      k_len_i = KW'(1);
      @(negedge clk);
      start_i = 1'b0;
    end
    n = 0;
    while (!done_o && n < 20000) begin @(negedge clk); n++; end
    check("done_seen", done_o, 1);
    done_cyc = cyc;
    check("err_flag", err_o, exp_err);
    @(negedge clk);
    stop_driver();
    check("op_accepts", accepts, exp_err ? 1 : kk);
    check("strobe_count", strobes, exp_err ? 1 : kk);
    check("results_left", exp_q.size(), 0);
  endtask

  task automatic reset_test();
    int n = 0;
    load_case(N, 0, 1);
    rdy_limit = 3;
    start_op(N);
    fork drive_ops(N, 0); join_none
    while (!(popped == 3 && bus.res_valid_o && bus.res_row_o == 2'd1 && bus.res_col_o == 2'd0)
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_beat4", bus.res_valid_o && bus.res_row_o == 2'd1, 1);
    rstn_i = 1'b0;
    #1;
    check("abort_outputs", outs_vec(), 0);
    @(posedge clk);
    #1;
    check("abort_outputs_next", outs_vec(), 0);
    exp_q.delete();
    rdy_limit = 1000000;
    stop_driver();
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  initial begin
    int el;
    bus.op_valid_i = 1'b0;
    bus.a_col_i    = '0;
    bus.b_row_i    = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
    check("mesh_rstn_release", bus.mesh_rstn_o, 1);
    check("idle_busy", busy_o, 0);

    run_op(3, 0, 0, 0, 0);                       // identity
    run_op(3, 1, 0, 0, 0);                       // dense
    rdy_pct = 40;
    run_op(3, 1, 6, 0, 0);                       // dense with stalls on both sides
    rdy_pct = 60;
    for (int t = 0; t < 4; t++) run_op($urandom_range(1, K_MAX), 2, 3, 0, 0);
    run_op(0, 2, 0, 0, 0);                       // no injection, all-zero results
    run_op(K_MAX + 3, 2, 2, 0, 0);               // clamped to K_MAX accepts
    rdy_pct = 100;

    pt11_off = 1;
    run_op(2, 2, 0, 1, 0);
    el = done_cyc - last_strobe_cyc;
    check("timeout_len", (el >= TIMEOUT && el <= TIMEOUT + 2), 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err_o, 1);
    pt11_off = 0;
    run_op(3, 0, 1, 0, 0);                       // err cleared by this start

    reset_test();
    run_op(3, 0, 1, 0, 1);                       // identity after reset, ignored mid-run start

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
